// File: rtl/mips_multi_cycle_controller.sv
// mips_multi_cycle_controller
// Moore control FSM for the multi-cycle MIPS datapath. It steps one state per
// cycle and drives every mux select, write enable and the ALU operation.
// Control outputs are flops loaded from the decode of the next state, so each
// state's controls appear on flop outputs for exactly the cycle the FSM is in it.
// The only combinational outputs are illegal_op, and the matching inst_done,
// while in ID. They depend on the IR contents, which only become valid in ID.
module mips_multi_cycle_controller #(
    parameter logic [1:0] RA_SEL  = 2'b10,
    parameter int         STATE_W = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       inst_done,
    output logic       illegal_op
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_IF,
        S_ID,
        S_EX_R,
        S_WB_R,
        S_EX_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_WB_LW,
        S_MEM_WR,
        S_BR,
        S_JMP,
        S_JAL,
        S_JR
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       inst_done;
    } ctrl_t;

    state_t state_q, state_d;
    logic   active_q, active_d;
    ctrl_t  ctrl_q, ctrl_d;

    logic       r_alu_ok;
    logic [2:0] r_alu_ctrl;
    logic       op_legal;
    logic       illegal_now;
    logic       unused_zero;

    // The branch decision is made in the datapath by ANDing pc_write_cond with zero.
    // The port is kept so the controller and datapath share the same interface.
    assign unused_zero = zero;

    // Decode the IR fields: the R-type function-to-ALU mapping and whether the opcode/func pair is supported.
    always_comb begin
        r_alu_ok   = 1'b1;
        r_alu_ctrl = ALU_ADD;
        op_legal   = 1'b0;
        case (func)
            F_ADD:   r_alu_ctrl = ALU_ADD;
            F_SUB:   r_alu_ctrl = ALU_SUB;
            F_AND:   r_alu_ctrl = ALU_AND;
            F_OR:    r_alu_ctrl = ALU_OR;
            F_SLT:   r_alu_ctrl = ALU_SLT;
            default: r_alu_ok   = 1'b0;
        endcase
        case (opcode)
            OP_R:                                               op_legal = r_alu_ok || (func == F_JR);
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_SLTI: op_legal = 1'b1;
            default:                                            op_legal = 1'b0;
        endcase
    end

    // Next-state logic. The first edge after reset release only enters IF, and any unknown state falls back to IF.
    always_comb begin
        state_d  = S_IF;
        active_d = 1'b1;
        if (active_q) begin
            case (state_q)
                S_IF: state_d = S_ID;
                S_ID: begin
                    case (opcode)
                        OP_R: begin
                            if (func == F_JR) begin
                                state_d = S_JR;
                            end else if (r_alu_ok) begin
                                state_d = S_EX_R;
                            end else begin
                                state_d = S_IF;
                            end
                        end
                        OP_ADDI, OP_SLTI: state_d = S_EX_I;
                        OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                        OP_BEQ:           state_d = S_BR;
                        OP_J:             state_d = S_JMP;
                        OP_JAL:           state_d = S_JAL;
                        default:          state_d = S_IF;
                    endcase
                end
                S_EX_R:     state_d = S_WB_R;
                S_EX_I:     state_d = S_WB_I;
                S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   state_d = S_WB_LW;
                default:    state_d = S_IF;
            endcase
        end
    end

    // Control decode of the state being entered. It is registered, so it shows up during that state's cycle.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_IF: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.alu_ctrl  = ALU_ADD;
            end
            S_ID: begin
                ctrl_d.alu_src_b = 2'b11;
                ctrl_d.alu_ctrl  = ALU_ADD;
            end
            S_EX_R: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b00;
                ctrl_d.alu_ctrl  = r_alu_ctrl;
            end
            S_WB_R: begin
                ctrl_d.reg_dst   = 2'b01;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.inst_done = 1'b1;
            end
            S_EX_I: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                ctrl_d.alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_WB_I: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.inst_done = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 2'b10;
                ctrl_d.alu_ctrl  = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_d.i_or_d   = 1'b1;
                ctrl_d.mem_read = 1'b1;
            end
            S_WB_LW: begin
                ctrl_d.mem_to_reg = 2'b01;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.inst_done  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_d.i_or_d    = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.inst_done = 1'b1;
            end
            S_BR: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_src_b     = 2'b00;
                ctrl_d.alu_ctrl      = ALU_SUB;
                ctrl_d.pc_write_cond = 1'b1;
                ctrl_d.pc_src        = 2'b01;
                ctrl_d.inst_done     = 1'b1;
            end
            S_JMP: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_src    = 2'b10;
                ctrl_d.inst_done = 1'b1;
            end
            S_JAL: begin
                ctrl_d.pc_write   = 1'b1;
                ctrl_d.pc_src     = 2'b10;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dst    = RA_SEL;
                ctrl_d.mem_to_reg = 2'b10;
                ctrl_d.inst_done  = 1'b1;
            end
            S_JR: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_src    = 2'b11;
                ctrl_d.inst_done = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    // State and control registers. An asynchronous reset clears the controls at once, so no partial write can complete.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IF;
            active_q <= 1'b0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign illegal_now = rst && active_q && (state_q == S_ID) && !op_legal;

    assign pc_write      = ctrl_q.pc_write;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign ir_write      = ctrl_q.ir_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_ctrl      = ctrl_q.alu_ctrl;
    assign pc_src        = ctrl_q.pc_src;
    assign inst_done     = ctrl_q.inst_done | illegal_now;
    assign illegal_op    = illegal_now;

endmodule

// File: tb/tb_mips_multi_cycle_controller.sv
// tb_mips_multi_cycle_controller
// Directed instruction sequences. Each instruction's per-cycle control vectors
// are queued when the instruction is issued. A separate monitor pops one entry
// per sampled cycle and compares it against the DUT outputs.
module tb_mips_multi_cycle_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] F_JR    = 6'b001000;

    logic       clock;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       inst_done, illegal_op;
    logic       probe;

    typedef struct {
        string       name;
        logic [20:0] vec;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   tests;
    int   errors;

    logic [5:0] r_funcs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] r_alus  [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};
    string      r_names [5] = '{"add", "sub", "and", "or", "slt"};

    mips_multi_cycle_controller dut (
        .clock        (clock),
        .rst          (rst),
        .opcode       (opcode),
        .func         (func),
        .zero         (zero),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_ctrl     (alu_ctrl),
        .pc_src       (pc_src),
        .inst_done    (inst_done),
        .illegal_op   (illegal_op)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Field order: pc_write pc_write_cond i_or_d mem_read mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a alu_src_b alu_ctrl pc_src inst_done illegal_op
    function automatic logic [20:0] ev(input logic pcw, input logic pwc, input logic iord, input logic mr,
                                       input logic mw, input logic irw, input logic [1:0] rd, input logic [1:0] mtr,
                                       input logic rw, input logic sa, input logic [1:0] sb, input logic [2:0] alu,
                                       input logic [1:0] ps, input logic dn, input logic il);
        return {pcw, pwc, iord, mr, mw, irw, rd, mtr, rw, sa, sb, alu, ps, dn, il};
    endfunction

    function automatic logic [20:0] e_if();
        return ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] e_id(input logic bad);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, bad, bad);
    endfunction
    function automatic logic [20:0] e_exr(input logic [2:0] alu);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, alu, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] e_exi(input logic [2:0] alu);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, alu, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] e_wb(input logic [1:0] rd, input logic [1:0] mtr);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rd, mtr, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0);
    endfunction
    function automatic logic [20:0] e_mem(input logic rd_en, input logic wr_en);
        return ev(1'b0, 1'b0, 1'b1, rd_en, wr_en, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, wr_en, 1'b0);
    endfunction
    function automatic logic [20:0] e_br();
        return ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01, 1'b1, 1'b0);
    endfunction
    function automatic logic [20:0] e_jump(input logic [1:0] ps, input logic link);
        return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, link ? 2'b10 : 2'b00, link ? 2'b10 : 2'b00, link,
                  1'b0, 2'b00, 3'b000, ps, 1'b1, 1'b0);
    endfunction

    // Queue one expected per-cycle control vector for the monitor.
    task automatic pushExpect(input string name, input logic [20:0] vec);
        exp_t e;
        e.name = name;
        e.vec  = vec;
        exp_q.push_back(e);
    endtask

    // Start a new instruction on the next rising edge, which is where its IF cycle begins.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
        @(posedge clock);
        #1;
        opcode = op;
        func   = fn;
        zero   = z;
    endtask

    // Let the remaining cycles of an n-cycle instruction elapse.
    task automatic waitRest(input int n);
        repeat (n - 1) @(posedge clock);
    endtask

    // Compare the DUT control outputs with one expected vector.
    task automatic checkOutput(input string name, input logic [20:0] want);
        logic [20:0] got;
        got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, inst_done, illegal_op};
        tests++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    // Monitor: sample once per cycle on the falling edge, or on an explicit probe pulse, and score against the queue.
    initial begin
        forever begin
            @(negedge clock or posedge probe);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                checkOutput(cur.name, cur.vec);
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        tests  = 0;
        errors = 0;
        probe  = 1'b0;
        rst    = 1'b0;
        opcode = 6'b0;
        func   = 6'b0;
        zero   = 1'b0;

        // Reset held for three edges; outputs stay zero until the first edge after release.
        pushExpect("reset.c1", 21'b0);
        pushExpect("reset.c2", 21'b0);
        pushExpect("reset.released", 21'b0);
        repeat (3) @(posedge clock);
        #1 rst = 1'b1;

        // R-type ALU operations.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(OP_R, r_funcs[i], 1'b0);
            pushExpect({r_names[i], ".IF"}, e_if());
            pushExpect({r_names[i], ".ID"}, e_id(1'b0));
            pushExpect({r_names[i], ".EX"}, e_exr(r_alus[i]));
            pushExpect({r_names[i], ".WB"}, e_wb(2'b01, 2'b00));
            waitRest(4);
        end

        // Immediate arithmetic.
        applyStimulus(OP_ADDI, 6'b010101, 1'b0);
        pushExpect("addi.IF", e_if());
        pushExpect("addi.ID", e_id(1'b0));
        pushExpect("addi.EX", e_exi(3'b010));
        pushExpect("addi.WB", e_wb(2'b00, 2'b00));
        waitRest(4);

        applyStimulus(OP_SLTI, 6'b000000, 1'b0);
        pushExpect("slti.IF", e_if());
        pushExpect("slti.ID", e_id(1'b0));
        pushExpect("slti.EX", e_exi(3'b111));
        pushExpect("slti.WB", e_wb(2'b00, 2'b00));
        waitRest(4);

        // Load and store.
        applyStimulus(OP_LW, 6'b000100, 1'b0);
        pushExpect("lw.IF", e_if());
        pushExpect("lw.ID", e_id(1'b0));
        pushExpect("lw.ADDR", e_exi(3'b010));
        pushExpect("lw.MEMRD", e_mem(1'b1, 1'b0));
        pushExpect("lw.WB", e_wb(2'b00, 2'b01));
        waitRest(5);

        applyStimulus(OP_SW, 6'b001000, 1'b0);
        pushExpect("sw.IF", e_if());
        pushExpect("sw.ID", e_id(1'b0));
        pushExpect("sw.ADDR", e_exi(3'b010));
        pushExpect("sw.MEMWR", e_mem(1'b0, 1'b1));
        waitRest(4);

        // Branch with zero set, then clear; the controls are identical either way.
        applyStimulus(OP_BEQ, 6'b000011, 1'b1);
        pushExpect("beq_z1.IF", e_if());
        pushExpect("beq_z1.ID", e_id(1'b0));
        pushExpect("beq_z1.BR", e_br());
        waitRest(3);

        applyStimulus(OP_BEQ, 6'b000011, 1'b0);
        pushExpect("beq_z0.IF", e_if());
        pushExpect("beq_z0.ID", e_id(1'b0));
        pushExpect("beq_z0.BR", e_br());
        waitRest(3);

        // Jumps.
        applyStimulus(OP_J, 6'b111000, 1'b0);
        pushExpect("j.IF", e_if());
        pushExpect("j.ID", e_id(1'b0));
        pushExpect("j.JMP", e_jump(2'b10, 1'b0));
        waitRest(3);

        applyStimulus(OP_JAL, 6'b000111, 1'b0);
        pushExpect("jal.IF", e_if());
        pushExpect("jal.ID", e_id(1'b0));
        pushExpect("jal.JAL", e_jump(2'b10, 1'b1));
        waitRest(3);

        applyStimulus(OP_R, F_JR, 1'b0);
        pushExpect("jr.IF", e_if());
        pushExpect("jr.ID", e_id(1'b0));
        pushExpect("jr.JR", e_jump(2'b11, 1'b0));
        waitRest(3);

        // Illegal opcode, then an illegal R-type function; each ends in ID.
        applyStimulus(6'b111111, 6'b000000, 1'b0);
        pushExpect("illop.IF", e_if());
        pushExpect("illop.ID", e_id(1'b1));
        waitRest(2);

        applyStimulus(OP_R, 6'b000001, 1'b0);
        pushExpect("illfn.IF", e_if());
        pushExpect("illfn.ID", e_id(1'b1));
        waitRest(2);

        // Follow-up add confirms the FSM returned to IF after the illegal instruction.
        applyStimulus(OP_R, 6'b100000, 1'b0);
        pushExpect("post_ill.IF", e_if());
        pushExpect("post_ill.ID", e_id(1'b0));
        pushExpect("post_ill.EX", e_exr(3'b010));
        pushExpect("post_ill.WB", e_wb(2'b01, 2'b00));
        waitRest(4);

        // Store interrupted by reset in MEM_WR: mem_write must drop as soon as rst falls.
        applyStimulus(OP_SW, 6'b000000, 1'b0);
        pushExpect("swrst.IF", e_if());
        pushExpect("swrst.ID", e_id(1'b0));
        pushExpect("swrst.ADDR", e_exi(3'b010));
        pushExpect("swrst.MEMWR", e_mem(1'b0, 1'b1));
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 rst = 1'b0;
        pushExpect("swrst.async_drop", 21'b0);
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        pushExpect("swrst.held", 21'b0);
        pushExpect("swrst.released", 21'b0);
        @(posedge clock);
        @(posedge clock);
        #1 rst = 1'b1;

        applyStimulus(OP_J, 6'b000000, 1'b0);
        pushExpect("restart.IF", e_if());
        pushExpect("restart.ID", e_id(1'b0));
        pushExpect("restart.JMP", e_jump(2'b10, 1'b0));
        waitRest(3);

        repeat (2) @(negedge clock);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
